// File: rtl/arith_pkg.sv
// Shared op codes, FSM state encoding and op-legality helper for seq_arith_unit.
// Honours SEQ_ARITH_REM_EN: when defined, op 100 (remainder) is a legal op.
package arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_REM = 3'b100
    } arith_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

    function automatic logic op_is_valid(input logic [2:0] op);
        logic ok;
        ok = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
`ifdef SEQ_ARITH_REM_EN
        ok = ok || (op == OP_REM);
`endif
        return ok;
    endfunction

    function automatic logic op_uses_divider(input logic [2:0] op);
        logic use_div;
        use_div = (op == OP_DIV);
`ifdef SEQ_ARITH_REM_EN
        use_div = use_div || (op == OP_REM);
`endif
        return use_div;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per cycle, MSB first.
// Remainder sign fix-up is only built when SEQ_ARITH_REM_EN is defined.
module seq_divider
    import arith_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W:0]   quotient,
    output logic [W-1:0] remainder,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dsr;
    logic          r_q_neg;
`ifdef SEQ_ARITH_REM_EN
    logic          r_r_neg;
`endif

    logic [W-1:0] w_dvd_mag;
    logic [W-1:0] w_dsr_mag;
    logic [W:0]   w_shift;
    logic [W:0]   w_diff;
    logic         w_fits;
    logic [W-1:0] w_rem_next;
    logic [W-1:0] w_quo_next;
    logic [W:0]   w_q_mag;

    // Magnitudes fit in W unsigned bits, including the most-negative operand.
    assign w_dvd_mag = dividend[W-1] ? (~dividend + W'(1)) : dividend;
    assign w_dsr_mag = divisor[W-1]  ? (~divisor  + W'(1)) : divisor;

    // Partial remainder stays below the divisor, so W+1 bits hold the shifted trial.
    assign w_shift    = {r_rem, r_quo[W-1]};
    assign w_diff     = w_shift - {1'b0, r_dsr};
    assign w_fits     = ~w_diff[W];
    assign w_rem_next = w_fits ? w_diff[W-1:0] : w_shift[W-1:0];
    assign w_quo_next = {r_quo[W-2:0], w_fits};

    assign done = r_run && (r_cnt == CW'(1));

    // Results are valid while done is high and are captured by the parent on that edge.
    assign w_q_mag  = {1'b0, w_quo_next};
    assign quotient = r_q_neg ? (~w_q_mag + (W+1)'(1)) : w_q_mag;
`ifdef SEQ_ARITH_REM_EN
    assign remainder = r_r_neg ? (~w_rem_next + W'(1)) : w_rem_next;
`else
    assign remainder = w_rem_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dsr   <= '0;
            r_q_neg <= 1'b0;
`ifdef SEQ_ARITH_REM_EN
            r_r_neg <= 1'b0;
`endif
        end else if (start) begin
            r_run   <= 1'b1;
            r_cnt   <= CW'(W);
            r_quo   <= w_dvd_mag;
            r_rem   <= '0;
            r_dsr   <= w_dsr_mag;
            r_q_neg <= dividend[W-1] ^ divisor[W-1];
`ifdef SEQ_ARITH_REM_EN
            r_r_neg <= dividend[W-1];
`endif
        end else if (r_run) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - CW'(1);
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential signed add/sub/mul/div(/rem) unit with valid/ready on both sides.
// SEQ_ARITH_REM_EN enables op 100 (signed remainder); otherwise op 100 reports err.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op_sel,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           err,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    // Handshake: a request transfers on an edge where in_valid && in_ready; a result
    // transfers on an edge where out_valid && out_ready. Each side holds until it transfers.

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUSY = ST_BUSY;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]     r_state;
    logic [2*W-1:0] r_result;
    logic           r_err;
    logic           r_is_rem;

    logic           w_accept;
    logic           w_op_ok;
    logic           w_use_div;
    logic           w_b_zero;
    logic           w_div_start;
    logic [2*W-1:0] w_a_ext;
    logic [2*W-1:0] w_b_ext;
    logic [2*W-1:0] w_fast;
    logic [W:0]     w_quot;
    logic [W-1:0]   w_rem;
    logic           w_div_done;
    logic [2*W-1:0] w_div_result;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY);
    assign result    = r_result;
    assign err       = r_err;
    assign dbg_state = r_state;

    assign w_accept    = in_valid && in_ready;
    assign w_op_ok     = op_is_valid(op_sel);
    assign w_use_div   = op_uses_divider(op_sel);
    assign w_b_zero    = (b == '0);
    assign w_div_start = w_accept && w_op_ok && w_use_div && !w_b_zero;

    assign w_a_ext = {{W{a[W-1]}}, a};
    assign w_b_ext = {{W{b[W-1]}}, b};

    // Working in 2W bits gives the exact W+1-bit sum/difference already sign-extended.
    always_comb begin
        w_fast = '0;
        case (op_sel)
            OP_ADD:  w_fast = w_a_ext + w_b_ext;
            OP_SUB:  w_fast = w_a_ext - w_b_ext;
            OP_MUL:  w_fast = w_a_ext * w_b_ext;
            default: w_fast = '0;
        endcase
    end

    assign w_div_result = r_is_rem ? {{W{w_rem[W-1]}}, w_rem}
                                   : {{(W-1){w_quot[W]}}, w_quot};

    seq_divider #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (a),
        .divisor   (b),
        .quotient  (w_quot),
        .remainder (w_rem),
        .done      (w_div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_err    <= 1'b0;
            r_is_rem <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= (op_sel == OP_REM);
                        if (!w_op_ok || (w_use_div && w_b_zero)) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_use_div) begin
                            r_err   <= 1'b0;
                            r_state <= S_BUSY;
                        end else begin
                            r_result <= w_fast;
                            r_err    <= 1'b0;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_div_done) begin
                        r_result <= w_div_result;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed plus random checks of seq_arith_unit (W=16) against a behavioural model.
// Honours SEQ_ARITH_REM_EN for the expected behaviour of op 100.
module tb_seq_arith_unit;

    localparam int W  = 16;
    localparam int RW = 2 * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op_sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          err;
    logic          busy;
    logic [1:0]    dbg_state;

    logic [RW:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    seq_arith_unit #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [RW:0] obs, input logic [RW:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: {err, result}
    function automatic logic [RW:0] model(input logic [2:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        longint la;
        longint lb;
        longint r;
        la = longint'($signed(x));
        lb = longint'($signed(y));
        r  = 0;
        case (op)
            3'd0: r = la + lb;
            3'd1: r = la - lb;
            3'd2: r = la * lb;
            3'd3: begin
                if (lb == 0) return {1'b1, {RW{1'b0}}};
                r = la / lb;
            end
`ifdef SEQ_ARITH_REM_EN
            3'd4: begin
                if (lb == 0) return {1'b1, {RW{1'b0}}};
                r = la % lb;
            end
`endif
            default: return {1'b1, {RW{1'b0}}};
        endcase
        return {1'b0, r[RW-1:0]};
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [W-1:0] y);
        logic div_op;
        div_op = (op == 3'd3);
`ifdef SEQ_ARITH_REM_EN
        div_op = div_op || (op == 3'd4);
`endif
        return (div_op && (y != '0)) ? W : 0;
    endfunction

    // Driver: present a request, wait for acceptance, push the expected result.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        op_sel   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_wait", (n < 50), 1);
        exp_q.push_back(model(op, x, y));
        step();
        in_valid = 1'b0;
        op_sel   = 3'($urandom_range(0, 7));
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // Wait for the result, compare, optionally hold it under backpressure, then take it.
    task automatic collect(input int exp_lat, input int hold);
        int n;
        int nb;
        logic [RW:0] got;
        logic [RW:0] expv;
        n  = 0;
        nb = 0;
        while (!out_valid && n < W + 10) begin
            if (busy) nb++;
            step();
            n++;
        end
        check("latency", n, exp_lat);
        check("busy_cycles", nb, exp_lat);
        check("queue_nonempty", (exp_q.size() > 0), 1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        got  = {err, result};
        check("result", got, expv);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            step();
            check("hold_stable", {err, result}, got);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [2:0]   r_op;
        logic [W-1:0] r_x;
        logic [W-1:0] r_y;
        logic         seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b1;
        op_sel    = 3'd0;
        a         = W'(1);
        b         = W'(1);
        out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_state", dbg_state, 0);

        // Fast ops, boundaries
        issue(3'd0, W'(30000), W'(10000));   collect(0, 0);
        issue(3'd2, W'(-32768), W'(-32768)); collect(0, 0);
        issue(3'd1, W'(-32768), W'(32767));  collect(0, 0);
        issue(3'd0, W'(32767), W'(32767));   collect(0, 0);

        // Divider
        issue(3'd3, W'(-7), W'(2));          collect(W, 0);
        issue(3'd4, W'(-7), W'(2));          collect(lat_of(3'd4, W'(2)), 0);
        issue(3'd3, W'(-32768), W'(-1));     collect(W, 0);
        issue(3'd3, W'(32767), W'(-32768));  collect(W, 0);

        // Errors
        issue(3'd3, W'(5), W'(0));           collect(0, 0);
        issue(3'd5, W'(5), W'(3));           collect(0, 0);
        issue(3'd7, W'(1), W'(1));           collect(0, 0);

        // Backpressure, then back-to-back accept
        issue(3'd0, W'(100), W'(-200));      collect(0, 5);
        issue(3'd1, W'(100), W'(-200));      collect(0, 0);

        // out_ready high before the result appears
        issue(3'd3, W'(1000), W'(-7));
        out_ready = 1'b1;
        collect(W, 0);

        // Reset in the middle of a divide
        issue(3'd3, W'(12345), W'(7));
        repeat (7) step();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid) seen_valid = 1'b1;
            step();
        end
        check("abort_no_result", seen_valid, 0);
        issue(3'd0, W'(-5), W'(12));         collect(0, 0);

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 5));
            r_x  = W'($urandom);
            r_y  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            issue(r_op, r_x, r_y);
            collect(lat_of(r_op, r_y), $urandom_range(0, 2));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
